ddr3_frame_prefetch: RTL and testbench

- Reads a framebuffer out of DDR3 through the MIG user (app_*) interface.
- Buffers 128-bit burst beats in a credit-managed FIFO.
- Delivers 16-bit pixels over a valid/ready stream to the HDMI video path.
- Sits between the MIG controller (upstream) and the video timing/TMDS stage (downstream). One frame is fetched per frame_start pulse.

---
 rtl/ddr3_frame_prefetch.sv | 206 ++++++++++++++++++++
 tb/tb_ddr3_frame_prefetch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_frame_prefetch.sv
// ddr3_frame_prefetch: fetches one framebuffer per frame_start through the MIG
// app_* read interface. 128-bit beats go into a credit-managed FIFO, and the
// block sends them out as 16-bit pixels with line and frame markers.
// Optional build macro: PREFETCH_STATS_EN adds the stall_cycles and
// max_outstanding statistics outputs.
module ddr3_frame_prefetch #(
    parameter int ADDR_W     = 27,
    parameter int BASE_ADDR  = 0,
    parameter int LINE_WORDS = 640,
    parameter int NUM_LINES  = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk_ref_i,
    input  logic              reset_rtl_0,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    input  logic [127:0]      app_rd_data,
    input  logic              app_rd_data_valid,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              underflow
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [4:0]        max_outstanding
`endif
);

    localparam int TOTAL_CMDS = LINE_WORDS * NUM_LINES / 8;
    localparam int CMD_W      = $clog2(TOTAL_CMDS + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int X_W        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int Y_W        = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state_q;
    logic              busy_q, app_en_q, done_q, underflow_q;
    logic [ADDR_W-1:0] app_addr_q;
    logic [CMD_W-1:0]  cmds_left_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, outs_q, outs_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_next;
    logic [127:0]      fifo_mem_q [FIFO_DEPTH];
    logic [127:0]      head_d;
    logic [2:0]        widx_q, widx_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [15:0]       pix_data_q;
    logic              pix_eol_q, pix_eof_q;
    logic              pix_acc, pop, beat_in, wr_ok, overflow, cmd_acc, credit_d;
    logic              x_last, y_last, acc_eof, starve;

    // Handshakes, occupancy next-state, and the head word shown on the next cycle.
    always_comb begin
        pix_acc  = (cnt_q != '0) && pix_ready;
        pop      = pix_acc && (widx_q == 3'd7);
        beat_in  = app_rd_data_valid && busy_q;     // stray beats while idle are ignored
        wr_ok    = beat_in && (cnt_q != CNT_W'(FIFO_DEPTH));
        overflow = beat_in && !wr_ok;
        cmd_acc  = app_en_q && app_rdy;
        cnt_d    = cnt_q + CNT_W'(wr_ok) - CNT_W'(pop);
        outs_d   = outs_q + CNT_W'(cmd_acc) - CNT_W'(beat_in);
        credit_d = ({1'b0, cnt_d} + {1'b0, outs_d}) < (CNT_W + 1)'(FIFO_DEPTH);
        x_last   = (x_q == X_W'(LINE_WORDS - 1));
        y_last   = (y_q == Y_W'(NUM_LINES - 1));
        acc_eof  = pix_acc && x_last && y_last;
        starve   = busy_q && (cnt_q == '0) && pix_ready && !done_q;
        x_d      = x_q;
        y_d      = y_q;
        if (pix_acc) begin
            x_d = x_last ? '0 : x_q + X_W'(1);
            if (x_last)
                y_d = y_last ? '0 : y_q + Y_W'(1);
        end
        widx_d   = widx_q + 3'(pix_acc);
        rd_next  = rd_ptr_q + PTR_W'(pop);
        // When the FIFO drains to empty this cycle, the incoming beat becomes the head.
        head_d   = ((cnt_q - CNT_W'(pop)) == '0) ? app_rd_data : fifo_mem_q[rd_next];
    end

    // Frame sequencing: credit-gated command issue and the busy window.
    always_ff @(posedge clk_ref_i or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            app_en_q    <= 1'b0;
            app_addr_q  <= ADDR_W'(BASE_ADDR);
            cmds_left_q <= '0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (frame_start) begin
                    state_q     <= ISSUE;
                    busy_q      <= 1'b1;
                    app_addr_q  <= ADDR_W'(BASE_ADDR);
                    cmds_left_q <= CMD_W'(TOTAL_CMDS);
                    done_q      <= 1'b0;
                end
                ISSUE: begin
                    if (cmd_acc) begin
                        app_addr_q  <= app_addr_q + ADDR_W'(8);
                        cmds_left_q <= cmds_left_q - CMD_W'(1);
                        if (cmds_left_q == CMD_W'(1)) begin
                            state_q  <= DRAIN;
                            app_en_q <= 1'b0;
                        end else begin
                            app_en_q <= credit_d;
                        end
                    end else if (!app_en_q) begin
                        app_en_q <= credit_d;   // once raised, hold until accepted
                    end
                end
                DRAIN: begin
                    if (acc_eof)
                        done_q <= 1'b1;
                    if ((done_q || acc_eof) && (cnt_d == '0) && (outs_d == '0)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset because cnt_q qualifies every read.
    always_ff @(posedge clk_ref_i) begin
        if (wr_ok)
            fifo_mem_q[wr_ptr_q] <= app_rd_data;
    end

    // FIFO pointers, credit counters, unpack index, position and pixel output registers.
    always_ff @(posedge clk_ref_i or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            cnt_q       <= '0;
            outs_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            widx_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pix_data_q  <= '0;
            pix_eol_q   <= 1'b0;
            pix_eof_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            outs_q   <= outs_d;
            rd_ptr_q <= rd_next;
            widx_q   <= widx_d;
            x_q      <= x_d;
            y_q      <= y_d;
            if (wr_ok)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (cnt_d != '0)
                pix_data_q <= head_d[{widx_d, 4'b0000} +: 16];
            pix_eol_q   <= (x_d == X_W'(LINE_WORDS - 1));
            pix_eof_q   <= (x_d == X_W'(LINE_WORDS - 1)) && (y_d == Y_W'(NUM_LINES - 1));
            underflow_q <= underflow_q | overflow | starve;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] stall_q;
    logic [4:0]  maxo_q;

    // Per-frame stall count (saturating) and outstanding-command high-water mark.
    always_ff @(posedge clk_ref_i or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            stall_q <= '0;
            maxo_q  <= '0;
        end else if (state_q == IDLE && frame_start) begin
            stall_q <= '0;
            maxo_q  <= '0;
        end else begin
            if (busy_q && pix_ready && (cnt_q == '0) && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
            if (5'(outs_q) > maxo_q)
                maxo_q <= 5'(outs_q);
        end
    end

    assign stall_cycles    = stall_q;
    assign max_outstanding = maxo_q;
`endif

    assign app_addr  = app_addr_q;
    assign app_cmd   = 3'b001;
    assign app_en    = app_en_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = (cnt_q != '0);
    assign pix_eol   = pix_eol_q;
    assign pix_eof   = pix_eof_q;
    assign busy      = busy_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_ddr3_frame_prefetch.sv
// Directed bench for ddr3_frame_prefetch: 16x4 frame, 4-entry FIFO, MIG model
// whose beat words equal their 16-bit word address, so pixel k carries value k.
module tb_ddr3_frame_prefetch;
  localparam int AW = 27, LW = 16, NL = 4, DEPTH = 4;
  localparam int NPIX = LW * NL, NCMD = NPIX / 8;

  logic clk = 1'b0;
  logic reset_rtl_0, frame_start, app_rdy, pix_ready;
  logic [AW-1:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en, app_rd_data_valid;
  logic [127:0] app_rd_data;
  logic [15:0] pix_data;
  logic pix_valid, pix_eol, pix_eof, busy, underflow;
`ifdef PREFETCH_STATS_EN
  logic [15:0] stall_cycles;
  logic [4:0] max_outstanding;
`endif

  int n_tests = 0, n_fail = 0;
  int cyc = 0, lat = 10;
  logic [AW-1:0] mq_addr[$];
  int mq_due[$];
  logic [AW-1:0] addr_log[$];
  logic [18:0] pix_log[$];   // {busy, eof, eol, data}
  bit occ_en = 1'b0;
  int tb_outs = 0, tb_cnt = 0, occ_pix = 0, max_occ = 0;

  ddr3_frame_prefetch #(.ADDR_W(AW), .BASE_ADDR(0), .LINE_WORDS(LW), .NUM_LINES(NL), .FIFO_DEPTH(DEPTH)) dut (
    .clk_ref_i(clk), .reset_rtl_0(reset_rtl_0), .frame_start(frame_start),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy), .underflow(underflow)
`ifdef PREFETCH_STATS_EN
    , .stall_cycles(stall_cycles), .max_outstanding(max_outstanding)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MIG model, pixel sink logger and independent occupancy model, all at negedge.
  always @(negedge clk) begin
    bit beat;
    beat = 1'b0;
    if (app_en && app_rdy) begin
      mq_addr.push_back(app_addr);
      mq_due.push_back(cyc + lat);
      addr_log.push_back(app_addr);
    end
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      for (int i = 0; i < 8; i++) app_rd_data[16*i +: 16] = 16'(mq_addr[0]) + 16'(i);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      beat = 1'b1;
    end
    app_rd_data_valid = beat;
    if (pix_valid && pix_ready) pix_log.push_back({busy, pix_eof, pix_eol, pix_data});
    if (!occ_en) begin
      tb_outs = 0; tb_cnt = 0; occ_pix = 0; max_occ = 0;
    end else begin
      tb_outs += int'(app_en && app_rdy) - int'(beat);
      if (pix_valid && pix_ready) begin
        if (occ_pix % 8 == 7) tb_cnt--;
        occ_pix++;
      end
      if (beat) tb_cnt++;
      if (tb_cnt + tb_outs > max_occ) max_occ = tb_cnt + tb_outs;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic wait_pixels(input int target, output bit to);
    to = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (pix_log.size() >= target) begin to = 1'b0; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [52:0] rst_exp;
    rst_exp = {1'b0, 27'd0, 3'b001, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    reset_rtl_0 = 1'b0; frame_start = 1'b0; app_rdy = 1'b1; pix_ready = 1'b1;
    tick(3);
    frame_start = 1'b1; tick(2); frame_start = 1'b0;
    n_tests++;
    if ({app_en, app_addr, app_cmd, pix_valid, pix_data, pix_eol, pix_eof, busy, underflow} !== rst_exp) begin
      n_fail++; $display("FAIL rst_held got %h exp %h",
        {app_en, app_addr, app_cmd, pix_valid, pix_data, pix_eol, pix_eof, busy, underflow}, rst_exp);
    end
    reset_rtl_0 = 1'b1; tick(2);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_start_ignored busy=%b exp 0", busy); end
    pulse_start(); tick(30);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_midframe_busy busy=%b exp 1", busy); end
    @(posedge clk); #3 reset_rtl_0 = 1'b0; #1;
    n_tests++;
    if ({app_en, app_addr, app_cmd, pix_valid, pix_data, pix_eol, pix_eof, busy, underflow} !== rst_exp) begin
      n_fail++; $display("FAIL rst_async got %h exp %h",
        {app_en, app_addr, app_cmd, pix_valid, pix_data, pix_eol, pix_eof, busy, underflow}, rst_exp);
    end
    tick(); reset_rtl_0 = 1'b1;
    tick(150);
    n_tests++;
    if ({underflow, pix_valid, busy, app_en} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_stray_beats {uf,pv,busy,en}=%b exp 0000", {underflow, pix_valid, busy, app_en});
    end
  endtask

  task automatic test_small_frame();
    bit to, found;
    int pb, ab;
    logic [18:0] exp, got;
    lat = 10; app_rdy = 1'b1; pix_ready = 1'b1;
    pb = pix_log.size(); ab = addr_log.size();
    pulse_start();
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL small_busy_rise busy=%b exp 1", busy); end
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (app_rd_data_valid) begin found = 1'b1; break; end
    end
    n_tests++;
    if (!found || pix_valid !== 1'b0) begin
      n_fail++; $display("FAIL small_first_beat found=%b pix_valid=%b exp 1/0", found, pix_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({pix_valid, pix_data, pix_eol} !== {1'b1, 16'd0, 1'b0}) begin
      n_fail++; $display("FAIL small_first_pix_latency got %h exp %h", {pix_valid, pix_data, pix_eol}, {1'b1, 16'd0, 1'b0});
    end
    wait_pixels(pb + NPIX, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL small_timeout pixels=%0d exp %0d", pix_log.size() - pb, NPIX); end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL small_busy_fall busy=%b exp 0", busy); end
    n_tests++;
    if (addr_log.size() - ab != NCMD) begin n_fail++; $display("FAIL small_cmd_count got %0d exp %0d", addr_log.size() - ab, NCMD); end
    for (int k = 0; k < NCMD; k++) begin
      n_tests++;
      if (ab + k >= addr_log.size() || addr_log[ab + k] !== AW'(8 * k)) begin
        n_fail++; $display("FAIL small_addr[%0d] got %0d exp %0d", k, (ab + k < addr_log.size()) ? addr_log[ab + k] : '1, 8 * k);
      end
    end
    for (int k = 0; k < NPIX; k++) begin
      exp = {1'b1, k == NPIX - 1, k % LW == LW - 1, 16'(k)};
      got = (pb + k < pix_log.size()) ? pix_log[pb + k] : '1;
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL small_pix[%0d] got %h exp %h", k, got, exp); end
    end
`ifdef PREFETCH_STATS_EN
    n_tests++;
    if (max_outstanding !== 5'd4) begin n_fail++; $display("FAIL small_max_outstanding got %0d exp 4", max_outstanding); end
`endif
  endtask

  task automatic test_cmd_stall();
    bit to;
    int pb, ab, n8;
    logic [18:0] exp, got;
    lat = 10; app_rdy = 1'b1; pix_ready = 1'b1;
    pb = pix_log.size(); ab = addr_log.size();
    pulse_start();
    for (int c = 0; c < 50; c++) begin
      if (addr_log.size() >= ab + 1) break;
      tick();
    end
    app_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (app_en !== 1'b1 || app_addr !== AW'(8)) begin
        n_fail++; $display("FAIL stall_hold[%0d] app_en=%b app_addr=%0d exp 1/8", i, app_en, app_addr);
      end
      tick();
    end
    n_tests++;
    if (addr_log.size() - ab != 1) begin n_fail++; $display("FAIL stall_no_accept got %0d accepts exp 1", addr_log.size() - ab); end
    app_rdy = 1'b1;
    wait_pixels(pb + NPIX, to);
    tick(2);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL stall_timeout pixels=%0d exp %0d", pix_log.size() - pb, NPIX); end
    n8 = 0;
    for (int k = ab; k < addr_log.size(); k++) if (addr_log[k] == AW'(8)) n8++;
    n_tests++;
    if (n8 != 1 || addr_log.size() - ab != NCMD) begin
      n_fail++; $display("FAIL stall_single_accept accepts_at_8=%0d total=%0d exp 1/%0d", n8, addr_log.size() - ab, NCMD);
    end
    for (int k = 0; k < NPIX; k++) begin
      exp = {1'b1, k == NPIX - 1, k % LW == LW - 1, 16'(k)};
      got = (pb + k < pix_log.size()) ? pix_log[pb + k] : '1;
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL stall_pix[%0d] got %h exp %h", k, got, exp); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int pb, ab;
    logic [18:0] exp, got;
    lat = 10; app_rdy = 1'b1; pix_ready = 1'b0; occ_en = 1'b1;
    tick();
    pb = pix_log.size(); ab = addr_log.size();
    pulse_start();
    tick(200);
    n_tests++;
    if ({app_en, pix_valid, pix_data} !== {1'b0, 1'b1, 16'd0}) begin
      n_fail++; $display("FAIL bp_full_hold got %h exp %h", {app_en, pix_valid, pix_data}, {1'b0, 1'b1, 16'd0});
    end
    n_tests++;
    if (addr_log.size() - ab != DEPTH) begin n_fail++; $display("FAIL bp_credit_cmds got %0d exp %0d", addr_log.size() - ab, DEPTH); end
    pix_ready = 1'b1;
    wait_pixels(pb + NPIX, to);
    tick(2);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL bp_timeout pixels=%0d exp %0d", pix_log.size() - pb, NPIX); end
    n_tests++;
    if (max_occ > DEPTH) begin n_fail++; $display("FAIL bp_occupancy got %0d exp <= %0d", max_occ, DEPTH); end
    for (int k = 0; k < NPIX; k++) begin
      exp = {1'b1, k == NPIX - 1, k % LW == LW - 1, 16'(k)};
      got = (pb + k < pix_log.size()) ? pix_log[pb + k] : '1;
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL bp_pix[%0d] got %h exp %h", k, got, exp); end
    end
    occ_en = 1'b0;
  endtask

  task automatic test_restart();
    bit to;
    int pb, ab;
    logic [18:0] exp, got;
    lat = 10; app_rdy = 1'b1; pix_ready = 1'b1;
    pb = pix_log.size(); ab = addr_log.size();
    pulse_start();
    wait_pixels(pb + 10, to);
    pulse_start();
    wait_pixels(pb + NPIX, to);
    tick(40);
    n_tests++;
    if (to || busy !== 1'b0) begin n_fail++; $display("FAIL restart_complete timeout=%b busy=%b exp 0/0", to, busy); end
    n_tests++;
    if (addr_log.size() - ab != NCMD) begin n_fail++; $display("FAIL restart_cmd_count got %0d exp %0d", addr_log.size() - ab, NCMD); end
    for (int k = 0; k < NCMD; k++) begin
      n_tests++;
      if (ab + k >= addr_log.size() || addr_log[ab + k] !== AW'(8 * k)) begin
        n_fail++; $display("FAIL restart_addr[%0d] got %0d exp %0d", k, (ab + k < addr_log.size()) ? addr_log[ab + k] : '1, 8 * k);
      end
    end
    n_tests++;
    if (pix_log.size() - pb != NPIX) begin n_fail++; $display("FAIL restart_pix_count got %0d exp %0d", pix_log.size() - pb, NPIX); end
    for (int k = 0; k < NPIX; k++) begin
      exp = {1'b1, k == NPIX - 1, k % LW == LW - 1, 16'(k)};
      got = (pb + k < pix_log.size()) ? pix_log[pb + k] : '1;
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL restart_pix[%0d] got %h exp %h", k, got, exp); end
    end
  endtask

  task automatic test_underflow();
    bit to;
    int pb;
    reset_rtl_0 = 1'b0; tick(2); reset_rtl_0 = 1'b1; tick(2);
    n_tests++;
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_cleared underflow=%b exp 0", underflow); end
    lat = 100; app_rdy = 1'b1; pix_ready = 1'b1;
    pb = pix_log.size();
    pulse_start();
    wait_pixels(pb + NPIX, to);
    tick(2);
    n_tests++;
    if (to || underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set timeout=%b underflow=%b exp 0/1", to, underflow); end
    tick(20);
    n_tests++;
    if (underflow !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL uf_sticky underflow=%b busy=%b exp 1/0", underflow, busy);
    end
`ifdef PREFETCH_STATS_EN
    n_tests++;
    if (stall_cycles < 16'd100) begin n_fail++; $display("FAIL uf_stall_cycles got %0d exp >= 100", stall_cycles); end
`endif
    lat = 10;
  endtask

  initial begin
    reset_rtl_0 = 1'b0; frame_start = 1'b0; app_rdy = 1'b1; pix_ready = 1'b1;
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    test_reset();
    test_small_frame();
    test_cmd_stall();
    test_backpressure();
    test_restart();
    test_underflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
